// File: rtl/pu_operand_feeder_pkg.sv
// Shared constants and types for the PU operand feeder.
package pu_operand_feeder_pkg;
   localparam int XLEN_DEFAULT = 5;
   localparam int PU_LATENCY   = 2;
   localparam int GROUP_SIZE   = 4;
   localparam int IDX_W        = $clog2(GROUP_SIZE);

   typedef logic [IDX_W-1:0] idx_t;
endpackage

// File: rtl/pu_operand_feeder_sync_fifo.sv
// First-word-fall-through result FIFO; push when full and pop when empty are ignored.
module pu_operand_feeder_sync_fifo #(
   parameter int WIDTH = 5,
   parameter int DEPTH = 4,
   localparam int AW   = $clog2(DEPTH),
   localparam int CW   = AW + 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] pop_data,
   output logic [CW-1:0]    count,
   output logic             full,
   output logic             empty
);
   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]    count_q, count_d;
   logic             do_push, do_pop;

   assign full     = (count_q == CW'(DEPTH));
   assign empty    = (count_q == '0);
   assign count    = count_q;
   assign pop_data = mem_q[rd_ptr_q];

   // Pointers wrap naturally because DEPTH is a power of two.
   always_comb begin
      do_push  = push & ~full;
      do_pop   = pop & ~empty;
      mem_d    = mem_q;
      if (do_push) mem_d[wr_ptr_q] = push_data;
      wr_ptr_d = wr_ptr_q + AW'(do_push);
      rd_ptr_d = rd_ptr_q + AW'(do_pop);
      count_d  = count_q + CW'(do_push) - CW'(do_pop);
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end
endmodule

// File: rtl/pu_operand_feeder.sv
// Packs a serial operand stream into 4-operand groups for a fixed-latency PU
// and buffers its results; issue is credit-gated so the PU can never overflow the FIFO.
module pu_operand_feeder
   import pu_operand_feeder_pkg::*;
#(
   parameter int XLEN      = XLEN_DEFAULT,
   parameter int LATENCY   = PU_LATENCY,
   parameter int OUT_DEPTH = 4
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [XLEN-1:0] in_data,
   input  logic            in_valid,
   output logic            in_ready,
   output logic [XLEN-1:0] num1,
   output logic [XLEN-1:0] num2,
   output logic [XLEN-1:0] num3,
   output logic [XLEN-1:0] num4,
   output logic            issue,
   input  logic [XLEN-1:0] pu_result,
   output logic [XLEN-1:0] res_data,
   output logic            res_valid,
   input  logic            res_ready,
   output logic            busy
);
   localparam int CW = $clog2(OUT_DEPTH) + 1;
   localparam int SW = CW + 1;

   logic [XLEN-1:0]    slot_q [GROUP_SIZE-1];
   logic [XLEN-1:0]    slot_d [GROUP_SIZE-1];
   logic [XLEN-1:0]    num_q  [GROUP_SIZE];
   logic [XLEN-1:0]    num_d  [GROUP_SIZE];
   idx_t               idx_q, idx_d;
   logic               issue_q, issue_d;
   logic [LATENCY-1:0] tok_q, tok_d;

   logic [CW-1:0]      inflight;
   logic [SW-1:0]      occupancy;
   logic               credit, last_beat, accept, fire;
   logic [CW-1:0]      fifo_count;
   logic               fifo_full, fifo_empty, fifo_push;

   always_comb begin
      // The issue cycle itself already owns a FIFO slot, before its token enters the pipe.
      inflight = CW'(issue_q);
      for (int i = 0; i < LATENCY; i++) inflight = inflight + CW'(tok_q[i]);
      occupancy = SW'(fifo_count) + SW'(inflight);
      credit    = occupancy < SW'(OUT_DEPTH);
      last_beat = (idx_q == idx_t'(GROUP_SIZE - 1));
      in_ready  = ~(last_beat & ~credit);
      accept    = in_valid & in_ready;
      fire      = accept & last_beat;

      idx_d = accept ? idx_q + idx_t'(1) : idx_q;

      slot_d = slot_q;
      for (int i = 0; i < GROUP_SIZE - 1; i++) begin
         if (accept && idx_q == idx_t'(i)) slot_d[i] = in_data;
      end

      num_d = num_q;
      if (fire) begin
         for (int i = 0; i < GROUP_SIZE - 1; i++) num_d[i] = slot_q[i];
         num_d[GROUP_SIZE-1] = in_data;
      end

      issue_d = fire;
      tok_d   = (tok_q << 1) | LATENCY'(issue_q);
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         slot_q  <= '{default: '0};
         num_q   <= '{default: '0};
         idx_q   <= '0;
         issue_q <= 1'b0;
         tok_q   <= '0;
      end else begin
         slot_q  <= slot_d;
         num_q   <= num_d;
         idx_q   <= idx_d;
         issue_q <= issue_d;
         tok_q   <= tok_d;
      end
   end

   // The oldest token marks the cycle in which pu_result belongs to a real group.
   assign fifo_push = tok_q[LATENCY-1] & ~fifo_full;

   pu_operand_feeder_sync_fifo #(
      .WIDTH (XLEN),
      .DEPTH (OUT_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (fifo_push),
      .push_data (pu_result),
      .pop       (res_ready),
      .pop_data  (res_data),
      .count     (fifo_count),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

   assign num1      = num_q[0];
   assign num2      = num_q[1];
   assign num3      = num_q[2];
   assign num4      = num_q[3];
   assign issue     = issue_q;
   assign res_valid = ~fifo_empty;
   assign busy      = (idx_q != '0) | issue_q | (|tok_q) | (fifo_count != '0);
endmodule

// File: tb/tb_pu_operand_feeder.sv
// Bench for pu_operand_feeder: queue-based reference model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_pu_operand_feeder;
   localparam int XLEN = 5;
   localparam int LAT  = 2;
   localparam int DEPTH = 4;

   logic            clk = 1'b0;
   logic            rst;
   logic [XLEN-1:0] in_data;
   logic            in_valid;
   logic            in_ready;
   logic [XLEN-1:0] num1, num2, num3, num4;
   logic            issue;
   logic [XLEN-1:0] pu_result;
   logic [XLEN-1:0] res_data;
   logic            res_valid;
   logic            res_ready;
   logic            busy;

   int checks = 0;
   int errs   = 0;
   int cyc    = 0;
   int acc_cnt = 0;
   int stall_cnt = 0;
   int issue_cyc[$];
   bit snd_done;

   pu_operand_feeder #(.XLEN(XLEN), .LATENCY(LAT), .OUT_DEPTH(DEPTH)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_data   (in_data),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .num1      (num1),
      .num2      (num2),
      .num3      (num3),
      .num4      (num4),
      .issue     (issue),
      .pu_result (pu_result),
      .res_data  (res_data),
      .res_valid (res_valid),
      .res_ready (res_ready),
      .busy      (busy)
   );

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   // Stand-in approximate PU: slot-wise mapping (12->19 in slot 1, 0->16 in slot 2,
   // 4->17 in slot 3), summed mod 32, two register stages.
   function automatic logic [XLEN-1:0] pu_fn(input logic [XLEN-1:0] a, b, c, d);
      return a + ~b + (c ^ 5'd16) + (d ^ 5'd21);
   endfunction

   logic [XLEN-1:0] pu_s1, pu_s2;
   always @(posedge clk) begin
      pu_s1 <= pu_fn(num1, num2, num3, num4);
      pu_s2 <= pu_s1;
   end
   assign pu_result = pu_s2;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // ---------------- driver tasks ----------------
   task automatic send(input logic [XLEN-1:0] d);
      bit acc;
      bit ok;
      ok = 1'b0;
      in_data  = d;
      in_valid = 1'b1;
      for (int k = 0; k < 200; k++) begin
         @(negedge clk);
         acc = in_ready;
         @(posedge clk);
         #1;
         if (acc) begin
            acc_cnt++;
            ok = 1'b1;
            break;
         end
         stall_cnt++;
      end
      if (!ok) begin
         checks++;
         errs++;
         $display("FAIL send_timeout: beat %0d never accepted", d);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // ---------------- reference model + scoreboard ----------------
   logic [XLEN-1:0] grp[$];
   logic [XLEN-1:0] exp_q[$];
   int              pend_cd[$];
   logic [XLEN-1:0] pend_v[$];
   logic [XLEN-1:0] exp_num[4];
   bit              exp_issue;
   bit              mvalid = 1'b0;

   always @(negedge clk) begin : model
      bit exp_ready;
      exp_ready = !(grp.size() == 3 && (exp_q.size() + pend_cd.size()) >= DEPTH);
      if (mvalid) begin
         chk("in_ready", in_ready, exp_ready);
         chk("issue", issue, exp_issue);
         chk("num1", num1, exp_num[0]);
         chk("num2", num2, exp_num[1]);
         chk("num3", num3, exp_num[2]);
         chk("num4", num4, exp_num[3]);
         chk("res_valid", res_valid, exp_q.size() != 0);
         if (exp_q.size() != 0) chk("res_data", res_data, exp_q[0]);
         chk("busy", busy, grp.size() != 0 || pend_cd.size() != 0 || exp_q.size() != 0);
         chk("push_while_full", {dut.tok_q[LAT-1], dut.fifo_full} == 2'b11, 0);
      end
      if (!rst) begin
         grp.delete();
         exp_q.delete();
         pend_cd.delete();
         pend_v.delete();
         exp_num = '{default: '0};
         exp_issue = 1'b0;
         mvalid = 1'b1;
      end else if (mvalid) begin
         if (res_ready && exp_q.size() != 0) void'(exp_q.pop_front());
         foreach (pend_cd[i]) pend_cd[i] = pend_cd[i] - 1;
         while (pend_cd.size() != 0 && pend_cd[0] == 0) begin
            void'(pend_cd.pop_front());
            exp_q.push_back(pend_v.pop_front());
         end
         exp_issue = 1'b0;
         if (in_valid && exp_ready) begin
            grp.push_back(in_data);
            if (grp.size() == 4) begin
               exp_num = '{grp[0], grp[1], grp[2], grp[3]};
               exp_issue = 1'b1;
               pend_cd.push_back(LAT + 1);
               pend_v.push_back(pu_fn(grp[0], grp[1], grp[2], grp[3]));
               grp.delete();
            end
         end
      end
   end

   always @(negedge clk) if (issue === 1'b1) issue_cyc.push_back(cyc);

   // ---------------- directed scenarios ----------------
   initial begin
      int pop_cyc;
      bit found;
      rst = 1'b0;
      in_valid = 1'b0;
      in_data = '0;
      res_ready = 1'b1;
      step(2);
      rst = 1'b1;
      @(negedge clk);
      chk("rst_in_ready", in_ready, 1);
      chk("rst_res_valid", res_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_issue", issue, 0);
      chk("rst_num1", num1, 0);

      // single group 3,12,0,4 -> 23
      step(1);
      send(5'd3); send(5'd12); send(5'd0); send(5'd4);
      in_valid = 1'b0;
      @(negedge clk);
      chk("t1_issue_T", issue, 1);
      chk("t1_num2", num2, 12);
      @(negedge clk);
      chk("t1_issue_T1", issue, 0);
      chk("t1_res_valid_T1", res_valid, 0);
      @(negedge clk);
      chk("t1_res_valid_T2", res_valid, 0);
      @(negedge clk);
      chk("t1_res_valid_T3", res_valid, 1);
      chk("t1_res_data", res_data, 23);

      // streaming 16 beats
      step(3);
      issue_cyc.delete();
      stall_cnt = 0;
      for (int i = 0; i < 16; i++) send(5'(i * 5 + 1));
      in_valid = 1'b0;
      step(10);
      chk("t2_stalls", stall_cnt, 0);
      chk("t2_issue_count", issue_cyc.size(), 4);
      for (int i = 1; i < issue_cyc.size(); i++)
         chk("t2_spacing", issue_cyc[i] - issue_cyc[i-1], 4);

      // backpressure: 24 beats with res_ready low
      res_ready = 1'b0;
      acc_cnt = 0;
      snd_done = 1'b0;
      fork
         begin
            for (int i = 0; i < 24; i++) send(5'(i + 7));
            in_valid = 1'b0;
            snd_done = 1'b1;
         end
      join_none
      found = 1'b0;
      for (int k = 0; k < 300; k++) begin
         @(negedge clk);
         if (in_ready === 1'b0) begin found = 1'b1; break; end
      end
      if (!found) begin
         checks++; errs++;
         $display("FAIL t3_stall_wait: in_ready never dropped");
      end
      repeat (10) @(negedge clk);
      chk("t3_accepted", acc_cnt, 19);
      chk("t3_in_ready", in_ready, 0);
      chk("t3_res_valid", res_valid, 1);
      issue_cyc.delete();
      step(1);
      res_ready = 1'b1;
      @(negedge clk);
      pop_cyc = cyc;
      for (int k = 0; k < 200 && !snd_done; k++) @(posedge clk);
      chk("t3_sender_done", snd_done, 1);
      step(20);
      chk("t3_late_issues", issue_cyc.size(), 2);
      if (issue_cyc.size() != 0) chk("t3_issue_after_pop", issue_cyc[0] - pop_cyc, 2);

      // simultaneous push/pop at count 2
      res_ready = 1'b0;
      send(5'd0); send(5'd0); send(5'd0); send(5'd0);
      send(5'd3); send(5'd12); send(5'd0); send(5'd4);
      in_valid = 1'b0;
      step(8);
      send(5'd1); send(5'd2); send(5'd3); send(5'd4);
      in_valid = 1'b0;
      step(1);
      step(1);
      res_ready = 1'b1;
      @(negedge clk);
      chk("t4_head_before", res_data, 4);
      step(1);
      res_ready = 1'b0;
      @(negedge clk);
      chk("t4_head_after", res_data, 23);
      step(1);
      res_ready = 1'b1;
      step(1);
      res_ready = 1'b0;
      @(negedge clk);
      chk("t4_third_valid", res_valid, 1);
      chk("t4_third_data", res_data, 2);
      step(1);
      res_ready = 1'b1;
      step(4);

      // reset with 2 beats held and one token in flight
      send(5'd20); send(5'd21); send(5'd22); send(5'd23);
      send(5'd5); send(5'd6);
      in_valid = 1'b0;
      rst = 1'b0;
      step(1);
      rst = 1'b1;
      @(negedge clk);
      chk("t5_in_ready", in_ready, 1);
      chk("t5_res_valid", res_valid, 0);
      chk("t5_busy", busy, 0);
      chk("t5_issue", issue, 0);
      step(6);
      chk("t5_no_late_capture", res_valid, 0);
      res_ready = 1'b0;
      send(5'd7); send(5'd8); send(5'd9); send(5'd10);
      in_valid = 1'b0;
      step(8);
      chk("t5_fresh_valid", res_valid, 1);
      chk("t5_fresh_data", res_data, 22);
      res_ready = 1'b1;
      step(3);

      // idle stability
      step(20);
      @(negedge clk);
      chk("t6_issue", issue, 0);
      chk("t6_res_valid", res_valid, 0);
      chk("t6_busy", busy, 0);
      chk("t6_num1", num1, 7);
      chk("t6_num4", num4, 10);

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end
endmodule

// File: doc/pu_operand_feeder.md
Name: pu_operand_feeder

Overview:
Upstream driver for the approximate processing unit (4 operands in, 1 sum out, fixed 2-cycle pipeline, no stall input).
- Accepts a serial valid/ready operand stream and packs every 4 accepted beats into one group.
- Drives the group onto num1..num4 for exactly one issue cycle, tracks the in-flight latency, and captures the returned result into an output FIFO.
- Presents results on a valid/ready stream; issue is credit-gated so a non-stallable PU can never overflow the FIFO.

Parameters:
XLEN, 5, operand/result width
LATENCY, 2, cycles from issue cycle T to the cycle in which PU result is valid (T+LATENCY)
OUT_DEPTH, 4, result FIFO entries (power of 2, >=2)

Ports:
clk  input  1  clock, rising edge
rst  input  1  synchronous, active-low reset
in_data  input  XLEN  operand beat
in_valid  input  1  operand beat valid
in_ready  output  1  feeder can accept beat
num1, num2, num3, num4  output  XLEN each  operands to PU (slot 0..3)
issue  output  1  one-cycle strobe; num1..num4 carry a real group this cycle
pu_result  input  XLEN  PU result
res_data  output  XLEN  result at FIFO head
res_valid  output  1  FIFO non-empty
res_ready  input  1  consumer takes result
busy  output  1  partial group held, or in-flight token, or FIFO non-empty

Behaviour:
- Reset (rst=0 at edge): idx=0, slots=0, num1..4=0, issue=0, token pipe cleared, FIFO pointers/count=0. Outputs: in_ready=1, res_valid=0, busy=0. Reset mid-operation discards the partial group, in-flight tokens and FIFO contents; results arriving later are ignored.
- Accept: beat taken when in_valid & in_ready. Write slot[idx], then idx wraps 0,1,2,3,0.
- Credit: credit = (fifo_count + inflight) < OUT_DEPTH, where inflight = number of set bits in the LATENCY-deep token pipe.
- in_ready = !(idx==3 & !credit): beats 0..2 are always accepted; the 4th beat is held off until credit exists.
- Issue: the edge accepting the 4th beat loads num1..num4 from slot0..2 plus in_data, and sets issue=1 for the next cycle T. A token enters the pipe.
- num1..num4 hold their value after T (PU samples every cycle, so only the token marks validity).
- Back-to-back groups issue every 4 cycles at most. Minimum spacing is 4 accepts, so tokens never collide.
- Capture: at the edge ending cycle T+LATENCY, the token exits the pipe and pu_result is pushed into the FIFO. Results with no token are never pushed.
- FIFO: first-word-fall-through. res_data = head entry, res_valid = count!=0. Pop on res_valid & res_ready.
- Simultaneous push and pop: count unchanged, both pointers advance, and pointers wrap modulo OUT_DEPTH.
- Full: credit guarantees push-while-full is impossible. The bench asserts it.
- Arithmetic: counts are width clog2(OUT_DEPTH)+1. There is no data arithmetic; values pass through unchanged.
- Pop from empty is ignored.

Decomposition:
- Shared package: XLEN default, PU_LATENCY=2, GROUP_SIZE=4, the idx width constant.
- Natural sub-module: sync_fifo (params WIDTH, DEPTH; push/pop/count/full/empty), instantiated once.
- Feeder top holds: slot registers, idx counter, token shift register, credit logic.

Test Plan:
1. Single group: beats 3, 12, 0, 4 with the real PU and res_ready=1.
   - issue pulses 1 cycle after the 4th accept.
   - res_valid rises T+LATENCY+1 with res_data=23.
   - Expected value: PU maps 12→19, 0→16, 4→17; sum 3+19+16+17 = 55 mod 32 = 23.
2. Streaming: 16 beats with in_valid held high and res_ready=1 → 4 issues exactly 4 cycles apart, 4 results in order, in_ready never drops.
3. Backpressure: res_ready=0 while 24 beats are offered.
   - 4 results are buffered, then in_ready=0 with idx==3; the 20th beat stalls.
   - Raise res_ready → stalled group issues only after the first pop, and no push occurs while full.
4. Simultaneous push/pop: with FIFO count=2, pop in the same cycle a result is captured → count stays 2 and order is preserved across pointer wrap.
5. Reset mid-operation: rst=0 for 1 cycle after 2 beats and with one token in flight.
   - Next cycle: in_ready=1, res_valid=0, busy=0, issue=0.
   - The late PU result is not captured; the next 4 beats form a fresh group.
6. Idle stability: no input → issue stays 0, res_valid stays 0, num1..4 hold their last value, busy=0.
